aes_enc_iter: RTL and testbench
===============================

Name: aes_enc_iter

Overview:
Iterative AES-128 encryption core. It is the forward-direction counterpart of the pipelined AES_dec block and shares its IN/KEY/enable/OUT conventions. It performs one round per clock and expands the round keys on the fly, so it needs no key pre-computation phase and no fsm_en. Produces ciphertext that AES_dec consumes in loopback benches.

Parameters:
NR, 10, number of AES rounds (fixed at 10 for AES-128; any other value is unsupported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
IN  input  128  plaintext block; byte 0 = IN[127:120], FIPS-197 column-major order
KEY  input  128  cipher key, same byte order
enable  input  1  start request; sampled only when busy=0
OUT  output  128  ciphertext; holds its value until the next completion
out_valid  output  1  one-cycle pulse when OUT is updated
busy  output  1  high from the accept edge up to and including the final-round edge

Behaviour:
- Reset (rst=0, async): OUT=0, out_valid=0, busy=0, state=0, round key=0, round counter=0, FSM=IDLE.
- FSM states: IDLE, ROUND.
- IDLE, enable=1 at edge E0:
  - state <= IN ^ KEY; rk <= KEY; rcon <= 8'h01; rnd <= 1; busy <= 1; go to ROUND.
  - IN and KEY are captured only at E0. Later changes are ignored.
- ROUND, edges E1..E10 (rnd = 1..10):
  - Next round key: rk' = expand(rk, rcon), using RotWord, SubWord and xor of rcon into the MSB.
  - rcon' = xtime(rcon). Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Round datapath: SubBytes -> ShiftRows -> MixColumns (omitted when rnd=10) -> xor rk'.
  - state <= result; rk <= rk'; rnd <= rnd+1.
- Completion at E10:
  - OUT <= final result; out_valid <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: ciphertext is visible on OUT in the cycle after E10, i.e. 10 clocks after the accept edge.
- Throughput: at most one block per 11 clocks.
- enable while busy=1 is ignored, including at E10. A request held high is accepted at E11.
- enable held high continuously produces back-to-back encryptions, one accept every 11 edges.
- out_valid and the acceptance of a new block may coincide (edge E11). Both take effect.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no out_valid is issued.
- X/Z on IN or KEY while idle with enable=0 must not propagate to OUT.
- Arithmetic is all GF(2^8):
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - MixColumns uses only xtime and xor; no multipliers.

Decomposition:
- Shared package aes_pkg:
  - constant NR
  - function xtime
  - functions mix_column (32-bit in/out) and shift_rows (128-bit)
  - rcon table; the same package serves AES_dec's inverse functions.
- Sub-module aes_sbox: combinational, 8-bit in/out, case-table forward S-box.
  - 20 instances: 16 for the state and 4 for SubWord in key expansion.
- The top module holds the FSM, counter, state/key registers and the round datapath.

Test Plan:
1. FIPS-197 C.1:
   - Stimulus: KEY=000102030405060708090a0b0c0d0e0f, IN=00112233445566778899aabbccddeeff, enable for 1 cycle.
   - Required: OUT=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid high exactly 10 clocks after the accept edge, and busy high for 10 cycles.
2. FIPS-197 App B:
   - Stimulus: KEY=2b7e151628aed2a6abf7158809cf4f3c, IN=3243f6a8885a308d313198a2e0370734.
   - Required: OUT=3925841d02dc09fbdc118597196a0b32.
3. All-zero key and plaintext:
   - Required: OUT=66e94bd4ef8a2c3b884cfa59ca342b2e.
4. Busy and back-to-back behaviour:
   - Change IN/KEY and pulse enable during busy: that request is ignored and the result still equals the C.1 vector.
   - Hold enable high with vector 1 then vector 2: out_valid pulses 11 clocks apart with the correct ciphertexts.
5. Reset during operation:
   - Drive rst=0 at round 5: OUT=0, busy=0, and no out_valid.
   - After release, re-running C.1 gives the correct result.
6. Loopback with AES_dec:
   - Feed OUT into AES_dec (same KEY, after its 10-cycle key-generation phase).
   - Required: decrypted output equals the original IN for 3 random vectors.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and GF(2^8) helpers for the encrypt/decrypt cores
package aes_pkg;
    localparam int NR = 10;
    localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef enum logic {IDLE, ROUND} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 2a0^3a1^a2^a3 rewritten as a0^t^xtime(a0^a1), t being the column parity
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = c;
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box as a combinational lookup table
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (x)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
            8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
            8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
            8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
            8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
            8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
            8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
            8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
            8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
            8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
            8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
            8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
            8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
            8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
            8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
            8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
            8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
            8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
            8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
            8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
            8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
            8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
            8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
            8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
            8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
            8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
            8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
            8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
            8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
            8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
            8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
            8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
            8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryption, one round per clock,
// round keys expanded on the fly alongside the data rounds
module aes_enc_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    input  logic         enable,
    output logic [127:0] OUT,
    output logic         out_valid,
    output logic         busy
);
    fsm_t st, st_nxt;
    logic [127:0] state, rk, rk_nxt, sub, sr, mc, res;
    logic [31:0] sw, tmp, k0, k1, k2, k3;
    logic [7:0] rcon;
    logic [3:0] rnd;
    logic last, accept;

    genvar i;
    for (i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.x(state[127-8*i -: 8]), .y(sub[127-8*i -: 8]));
    end
    // SubWord before RotWord is equivalent since both act bytewise
    for (i = 0; i < 4; i++) begin : g_kb
        aes_sbox u_kb (.x(rk[31-8*i -: 8]), .y(sw[31-8*i -: 8]));
    end
    for (i = 0; i < 4; i++) begin : g_mc
        assign mc[127-32*i -: 32] = mix_column(sr[127-32*i -: 32]);
    end

    assign tmp    = {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
    assign k0     = rk[127:96] ^ tmp;
    assign k1     = rk[95:64] ^ k0;
    assign k2     = rk[63:32] ^ k1;
    assign k3     = rk[31:0] ^ k2;
    assign rk_nxt = {k0, k1, k2, k3};
    assign sr     = shift_rows(sub);
    assign last   = (rnd == 4'(NR));
    assign res    = (last ? sr : mc) ^ rk_nxt;
    assign busy   = (st == ROUND);

    always_comb begin
        accept = (st == IDLE) && enable;
        st_nxt = accept ? ROUND : (busy && last) ? IDLE : st;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else st <= st_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT       <= '0;
            out_valid <= 1'b0;
            state     <= '0;
            rk        <= '0;
            rcon      <= '0;
            rnd       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                state <= IN ^ KEY;
                rk    <= KEY;
                rcon  <= RCON[0];
                rnd   <= 4'd1;
            end else if (busy) begin
                state <= res;
                rk    <= rk_nxt;
                rcon  <= xtime(rcon);
                rnd   <= rnd + 4'd1;
                if (last) begin
                    OUT       <= res;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: known-answer, random and multi-cycle corner checks for aes_enc_iter
// against a byte-level FIPS-197 cipher/inverse-cipher model.
module tb_aes_enc_iter;
    logic clk = 1'b0;
    logic rst, enable, out_valid, busy;
    logic [127:0] IN, KEY, OUT;
    int n_vec = 0, n_miss = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    typedef struct { logic [127:0] pt, key, ct; } vec_t;
    vec_t tv [3];

    aes_enc_iter dut (.clk(clk), .rst(rst), .IN(IN), .KEY(KEY), .enable(enable),
                      .OUT(OUT), .out_valid(out_valid), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] bget(input logic [127:0] v, input int k);
        return v[127-8*k -: 8];
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 0; k < 4; k++) w[k] = key[127-32*k -: 32];
        for (int k = 4; k < 44; k++) begin
            t = w[k-1];
            if (k % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[k] = w[k-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] enc_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, t;
        s = pt ^ round_key(key, 0);
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++)
                t[127-8*k -: 8] = sb[bget(s, k % 4 + 4 * ((k / 4 + k % 4) % 4))];
            s = t;
            if (r < 10)
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[127-8*(4*c+j) -: 8] = gmul(8'd2, bget(t, 4*c+j)) ^ gmul(8'd3, bget(t, 4*c+(j+1)%4))
                                              ^ bget(t, 4*c+(j+2)%4) ^ bget(t, 4*c+(j+3)%4);
            s ^= round_key(key, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] dec_ref(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] s, t;
        s = ct ^ round_key(key, 10);
        for (int r = 9; r >= 0; r--) begin
            for (int k = 0; k < 16; k++)
                t[127-8*k -: 8] = isb[bget(s, k % 4 + 4 * ((k / 4 - k % 4 + 4) % 4))];
            t ^= round_key(key, r);
            s = t;
            if (r > 0)
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[127-8*(4*c+j) -: 8] = gmul(8'd14, bget(t, 4*c+j)) ^ gmul(8'd11, bget(t, 4*c+(j+1)%4))
                                              ^ gmul(8'd13, bget(t, 4*c+(j+2)%4)) ^ gmul(8'd9, bget(t, 4*c+(j+3)%4));
        end
        return s;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one block, scramble IN/KEY after the accept edge, then measure latency and busy width.
    task automatic do_block(input string nm, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp);
        int lat, bcnt;
        lat = -1;
        bcnt = 0;
        @(negedge clk);
        IN = pt; KEY = key; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0; IN = rnd128(); KEY = rnd128();
        bcnt += int'(busy);
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) lat = n;
            bcnt += int'(busy);
        end
        check({nm, "_out"}, OUT, exp);
        check({nm, "_latency"}, 128'(lat), 128'd10);
        check({nm, "_busy_cycles"}, 128'(bcnt), 128'd10);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_valid_width"}, 128'(out_valid), 128'd0);
    endtask

    // Start C.1, then request a different block with enable high at edge E<k> while busy.
    task automatic busy_poke(input string nm, input int k);
        int n, bcnt;
        @(negedge clk);
        IN = tv[0].pt; KEY = tv[0].key; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (k - 1) begin @(posedge clk); @(negedge clk); end
        IN = rnd128(); KEY = rnd128(); enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        check({nm, "_valid_seen"}, 128'(out_valid), 128'd1);
        check({nm, "_out"}, OUT, tv[0].ct);
        bcnt = 0;
        repeat (15) begin @(posedge clk); @(negedge clk); bcnt += int'(busy); end
        check({nm, "_no_accept"}, 128'(bcnt), 128'd0);
    endtask

    initial begin
        logic [7:0] inv;
        int t, vcnt, bcnt;
        int tq[$];
        logic [127:0] oq[$];
        logic [127:0] pt, key, ct;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[sb[x]] = 8'(x);
        end
        tv[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tv[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32};
        tv[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        rst = 1'b1; enable = 1'b0; IN = '0; KEY = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", OUT, 128'h0);
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 3; v++) do_block($sformatf("kat%0d", v), tv[v].pt, tv[v].key, tv[v].ct);

        IN = 'x; KEY = 'x;
        repeat (5) @(negedge clk);
        check("idle_x_out", OUT, tv[2].ct);
        check("idle_x_busy", 128'(busy), 128'd0);

        busy_poke("poke_mid", 3);
        busy_poke("poke_final", 10);

        // enable held high: vector 1 accepted at E0, vector 2 at E11
        tq.delete(); oq.delete();
        t = 0;
        @(negedge clk);
        IN = tv[0].pt; KEY = tv[0].key; enable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); t++;
            @(negedge clk);
            if (out_valid) begin tq.push_back(t); oq.push_back(OUT); end
            if (t == 1) begin IN = tv[1].pt; KEY = tv[1].key; end
            if (t == 12) enable = 1'b0;
        end
        check("b2b_pulses", 128'(tq.size()), 128'd2);
        check("b2b_out1", oq.size() > 0 ? oq[0] : 128'h0, tv[0].ct);
        check("b2b_out2", oq.size() > 1 ? oq[1] : 128'h0, tv[1].ct);
        check("b2b_gap", 128'(tq.size() > 1 ? tq[1] - tq[0] : 0), 128'd11);

        // reset in round 5 aborts the block with no completion pulse
        @(negedge clk);
        IN = tv[0].pt; KEY = tv[0].key; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        #1;
        check("abort_out", OUT, 128'h0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_valid", 128'(out_valid), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcnt = 0; bcnt = 0;
        repeat (15) begin @(posedge clk); @(negedge clk); vcnt += int'(out_valid); bcnt += int'(busy); end
        check("abort_no_valid", 128'(vcnt), 128'd0);
        check("abort_no_busy", 128'(bcnt), 128'd0);
        do_block("rerun_c1", tv[0].pt, tv[0].key, tv[0].ct);

        for (int v = 0; v < 16; v++) begin
            pt = rnd128(); key = rnd128();
            ct = enc_ref(pt, key);
            do_block($sformatf("rand%0d", v), pt, key, ct);
            if (v < 3) check($sformatf("loopback%0d", v), dec_ref(OUT, key), pt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
